// File: rtl/rtcomp_mc.sv
// rtcomp_mc: route computation for a 2D-mesh router with multicast support.
// Unicast headers are routed XY in a single cycle. A multicast header is split
// into one branch descriptor per non-empty output partition (order L, N, E, S, W),
// one descriptor per downstream handshake.
module rtcomp_mc #(
  parameter  int MY_XPOS = 0,
  parameter  int MY_YPOS = 0,
  parameter  int XSIZE   = 4,
  parameter  int YSIZE   = 4,
  parameter  int VCH     = 2,
  localparam int NODES   = XSIZE * YSIZE,
  localparam int NW      = (NODES > 1) ? $clog2(NODES) : 1,
  localparam int VW      = (VCH > 1) ? $clog2(VCH) : 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mcast,
  input  logic [NW-1:0]    in_udst,
  input  logic [NODES-1:0] in_mdst,
  input  logic [VW-1:0]    in_vch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_port,
  output logic [VW-1:0]    out_vch,
  output logic [NODES-1:0] out_dmask,
  output logic             out_last,
  output logic             out_err
);

  typedef enum logic {S_IDLE, S_BRANCH} state_t;

  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_N = 5'b00010;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_W = 5'b10000;

  // An out-of-range unicast index is only representable when NODES is not a power of two.
  localparam bit UDST_CAN_OVF = (2 ** NW) > NODES;

  // Static destination partition of the mesh as seen from this router.
  function automatic logic [NODES-1:0] part_mask(input int dir);
    logic [NODES-1:0] m;
    int x, y;
    m = '0;
    for (int n = 0; n < NODES; n++) begin
      x = n % XSIZE;
      y = n / XSIZE;
      case (dir)
        0:       m[n] = (x == MY_XPOS) && (y == MY_YPOS);
        1:       m[n] = (x == MY_XPOS) && (y <  MY_YPOS);
        2:       m[n] = (x >  MY_XPOS);
        3:       m[n] = (x == MY_XPOS) && (y >  MY_YPOS);
        default: m[n] = (x <  MY_XPOS);
      endcase
    end
    return m;
  endfunction

  localparam logic [NODES-1:0] M_L = part_mask(0);
  localparam logic [NODES-1:0] M_N = part_mask(1);
  localparam logic [NODES-1:0] M_E = part_mask(2);
  localparam logic [NODES-1:0] M_S = part_mask(3);
  localparam logic [NODES-1:0] M_W = part_mask(4);

  state_t           r_state, w_state_nxt;
  logic [NODES-1:0] r_resid;
  logic             r_valid, r_last, r_err;
  logic [4:0]       r_port;
  logic [VW-1:0]    r_vch;
  logic [NODES-1:0] r_dmask;

  logic             w_accept, w_adv;
  logic [NODES-1:0] w_src, w_sel_mask, w_rem, w_umask;
  logic [4:0]       w_sel_port, w_uport;
  logic             w_uerr;
  int               w_ux, w_uy;

  assign in_ready = (r_state == S_IDLE) && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_adv    = (r_state == S_BRANCH) && r_valid && out_ready;

  // Branches are carved from the incoming bitmap on acceptance, else from the residual.
  assign w_src = (r_state == S_IDLE) ? in_mdst : r_resid;

  // Pick the first non-empty partition in L, N, E, S, W order and what is left after it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_sel_port = '0;
    w_sel_mask = '0;
    if      (|(w_src & M_L)) begin w_sel_port = P_L; w_sel_mask = w_src & M_L; end
    else if (|(w_src & M_N)) begin w_sel_port = P_N; w_sel_mask = w_src & M_N; end
    else if (|(w_src & M_E)) begin w_sel_port = P_E; w_sel_mask = w_src & M_E; end
    else if (|(w_src & M_S)) begin w_sel_port = P_S; w_sel_mask = w_src & M_S; end
    else if (|(w_src & M_W)) begin w_sel_port = P_W; w_sel_mask = w_src & M_W; end
    w_rem = w_src & ~w_sel_mask;
  end

  // XY routing of a unicast destination; bad indices go to L with an empty mask.
  always_comb begin
    w_ux    = int'(in_udst) % XSIZE;
    w_uy    = int'(in_udst) / XSIZE;
    w_uerr  = UDST_CAN_OVF && (int'(in_udst) >= NODES);
    w_uport = P_L;
    w_umask = '0;
    if (!w_uerr) begin
      w_umask = NODES'(1) << in_udst;
      if      (w_ux > MY_XPOS) w_uport = P_E;
      else if (w_ux < MY_XPOS) w_uport = P_W;
      else if (w_uy < MY_YPOS) w_uport = P_N;
      else if (w_uy > MY_YPOS) w_uport = P_S;
      else                     w_uport = P_L;
    end
  end

  // Next state: stay in BRANCH while a residual remains after the branch being loaded.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && in_mcast && (w_rem != '0)) w_state_nxt = S_BRANCH;
      S_BRANCH: if (w_adv && (w_rem == '0))                w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Descriptor register and residual bitmap; fields only change on accept or advance.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_resid <= '0;
      r_valid <= 1'b0;
      r_port  <= '0;
      r_vch   <= '0;
      r_dmask <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_vch <= in_vch;
        if (!in_mcast) begin
          r_valid <= 1'b1;
          r_port  <= w_uport;
          r_dmask <= w_umask;
          r_last  <= 1'b1;
          r_err   <= w_uerr;
          r_resid <= '0;
        end else if (in_mdst == '0) begin
          r_valid <= 1'b0;
          r_resid <= '0;
        end else begin
          r_valid <= 1'b1;
          r_port  <= w_sel_port;
          r_dmask <= w_sel_mask;
          r_last  <= (w_rem == '0);
          r_resid <= w_rem;
        end
      end else if (w_adv) begin
        r_port  <= w_sel_port;
        r_dmask <= w_sel_mask;
        r_last  <= (w_rem == '0);
        r_resid <= w_rem;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_port  = r_port;
  assign out_vch   = r_vch;
  assign out_dmask = r_dmask;
  assign out_last  = r_last;
  assign out_err   = r_err;

endmodule

// File: doc/rtcomp_mc.md
RTCOMP_MC -- requirements
Module: rtcomp_mc

Interface
REQ-001 Parameter MY_XPOS, default 0: X coordinate of this router.
REQ-002 Parameter MY_YPOS, default 0: Y coordinate of this router.
REQ-003 Parameter XSIZE, default 4: mesh columns; YSIZE, default 4: mesh rows; NODES = XSIZE*YSIZE, NW = clog2(NODES).
REQ-004 Parameter VCH, default 2: VC count; VW = max(1, clog2(VCH)).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 in_valid  input  1  header flit present.
REQ-008 in_ready  output  1  block accepts header this cycle.
REQ-009 in_mcast  input  1  1 = multicast, 0 = unicast.
REQ-010 in_udst  input  NW  unicast destination index, node = y*XSIZE + x.
REQ-011 in_mdst  input  NODES  multicast destination bitmap, bit n = node n.
REQ-012 in_vch  input  VW  input VC.
REQ-013 out_valid  output  1  branch descriptor valid.
REQ-014 out_ready  input  1  downstream consumes descriptor.
REQ-015 out_port  output  5  one-hot port: bit0 L, bit1 N, bit2 E, bit3 S, bit4 W.
REQ-016 out_vch  output  VW  output VC, equal to accepted in_vch.
REQ-017 out_dmask  output  NODES  destinations carried on this branch (unicast: single bit of in_udst).
REQ-018 out_last  output  1  final branch of the current header.
REQ-019 out_err  output  1  one-cycle pulse: unicast in_udst >= NODES accepted.

Function
REQ-020 Accept when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-021 Unicast routing is XY: x>MY_XPOS -> E; x<MY_XPOS -> W; x equal and y<MY_YPOS -> N; y>MY_YPOS -> S; both equal -> L.
REQ-022 Multicast partition: L = own node; E = all nodes x>MY_XPOS; W = all nodes x<MY_XPOS; N = x==MY_XPOS, y<MY_YPOS; S = x==MY_XPOS, y>MY_YPOS.
REQ-023 Outputs are registered: descriptor appears the cycle after acceptance (latency 1).
REQ-024 Unicast: one descriptor, out_last=1, state remains IDLE; back-to-back unicasts sustain one per cycle with out_ready=1.
REQ-025 Multicast: branches with non-zero partition emitted one per handshake in fixed order L, N, E, S, W; out_last=1 on the final one.
REQ-026 FSM IDLE -> BRANCH on multicast acceptance with more than one non-empty partition; BRANCH holds the residual bitmap and loads the next branch on out_valid && out_ready; BRANCH -> IDLE when the last branch is loaded.
REQ-027 Multicast with exactly one non-empty partition: single descriptor, out_last=1, stays IDLE.
REQ-028 Multicast with in_mdst == 0: accepted and dropped, no descriptor, out_valid stays 0.
REQ-029 Unicast in_udst >= NODES: routed to L, out_dmask = 0, out_err pulses in the descriptor cycle.
REQ-030 While out_valid && !out_ready, out_port/out_vch/out_dmask/out_last hold stable and in_ready = 0.
REQ-031 out_valid clears on handshake if no further branch or accepted header exists.
REQ-032 OR of all out_dmask values for one multicast equals in_mdst; partitions are disjoint.

Reset
REQ-033 rst_ low asynchronously forces state IDLE, residual bitmap 0, out_valid 0, out_port 0, out_vch 0, out_dmask 0, out_last 0, out_err 0.
REQ-034 Reset mid-multicast discards remaining branches; first cycle after release in_ready = 1.

Verification (MY_XPOS=1, MY_YPOS=1, 4x4, VCH=2)
REQ-035 Unicast in_udst=3, in_vch=1 -> next cycle out_port=00100, out_dmask=0x0008, out_vch=1, out_last=1.
REQ-036 Multicast in_mdst=0x00B0 (nodes 4,5,7), out_ready=1 -> three cycles: L/0x0020, E/0x0080, W/0x0010 (out_last=1); in_ready low in between.
REQ-037 Same multicast with out_ready low 3 cycles on the first branch -> L/0x0020 held unchanged, then sequence resumes.
REQ-038 Multicast in_mdst=0 -> no out_valid; next unicast accepted the following cycle.
REQ-039 Unicast in_udst=5 -> out_port=00001; in_udst=1 -> out_port=00010; in_udst=9 -> out_port=01000.
REQ-040 rst_ pulsed low during second multicast branch -> all outputs 0 immediately, in_ready=1 after release, no stale branches.
